// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy coin payout sequencer driving quarter/dime/nickel eject solenoids
module change_dispenser #(
  parameter int AMT_W     = 8,
  parameter int PULSE_CYC = 4,
  parameter int GAP_CYC   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             n_out,
  output logic             di_out,
  output logic             q_out
);

  localparam int CNT_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, SELECT, PULSE, GAP, DONE} state_t;

  state_t           state, state_nx;
  logic [AMT_W-1:0] remaining, remaining_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             busy_nx, done_nx, err_nx, n_nx, di_nx, q_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      n_out     <= 1'b0;
      di_out    <= 1'b0;
      q_out     <= 1'b0;
    end else begin
      state     <= state_nx;
      remaining <= remaining_nx;
      cnt       <= cnt_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      err       <= err_nx;
      n_out     <= n_nx;
      di_out    <= di_nx;
      q_out     <= q_nx;
    end
  end

  // Outputs are computed one state ahead so every pin comes straight from a flop.
  always_comb begin
    state_nx     = state;
    remaining_nx = remaining;
    cnt_nx       = cnt;
    busy_nx      = busy;
    done_nx      = 1'b0;
    err_nx       = 1'b0;
    n_nx         = n_out;
    di_nx        = di_out;
    q_nx         = q_out;
    case (state)
      IDLE: begin
        busy_nx = 1'b0;
        n_nx    = 1'b0;
        di_nx   = 1'b0;
        q_nx    = 1'b0;
        if (start) begin
          if ((amount % AMT_W'(5)) != '0) begin
            err_nx = 1'b1;
          end else begin
            remaining_nx = amount;
            busy_nx      = 1'b1;
            state_nx     = SELECT;
          end
        end
      end
      SELECT: begin
        cnt_nx = '0;
        if (remaining >= AMT_W'(25)) begin
          q_nx         = 1'b1;
          remaining_nx = remaining - AMT_W'(25);
          state_nx     = PULSE;
        end else if (remaining >= AMT_W'(10)) begin
          di_nx        = 1'b1;
          remaining_nx = remaining - AMT_W'(10);
          state_nx     = PULSE;
        end else if (remaining >= AMT_W'(5)) begin
          n_nx         = 1'b1;
          remaining_nx = remaining - AMT_W'(5);
          state_nx     = PULSE;
        end else begin
          done_nx  = 1'b1;
          state_nx = DONE;
        end
      end
      PULSE: begin
        if (cnt == CNT_W'(PULSE_CYC - 1)) begin
          n_nx     = 1'b0;
          di_nx    = 1'b0;
          q_nx     = 1'b0;
          cnt_nx   = '0;
          state_nx = GAP;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt == CNT_W'(GAP_CYC - 1)) begin
          cnt_nx   = '0;
          state_nx = SELECT;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
      default: begin
        busy_nx  = 1'b0;
        n_nx     = 1'b0;
        di_nx    = 1'b0;
        q_nx     = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - randomized directed bench for change_dispenser against an arithmetic payout model
module tb_change_dispenser;
  localparam int AMT_W = 8;
  localparam int P     = 4;
  localparam int G     = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [AMT_W-1:0] amount;
  logic             busy, done, err, n_out, di_out, q_out;

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  int obs_q[$];

  change_dispenser #(.AMT_W(AMT_W), .PULSE_CYC(P), .GAP_CYC(G)) dut (
    .clk(clk), .rst(rst), .start(start), .amount(amount),
    .busy(busy), .done(done), .err(err),
    .n_out(n_out), .di_out(di_out), .q_out(q_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int outs();
    return int'({busy, done, err, n_out, di_out, q_out});
  endfunction

  // Greedy model: 3=quarter, 2=dime, 1=nickel, in payout order.
  task automatic build_model(input int a);
    int r;
    exp_q.delete();
    repeat (a / 25) exp_q.push_back(3);
    r = a % 25;
    repeat (r / 10) exp_q.push_back(2);
    r = r % 10;
    repeat (r / 5) exp_q.push_back(1);
  endtask

  task automatic payout(input int a, input int inject_c, input string tag);
    int c, cur, done_c, fall_c, done_cnt, width, low, seen, mism;
    int width_err, gap_err, oh_err, busy_err;
    c = 1; done_c = -1; fall_c = -1; done_cnt = 0; width = 0; low = 0; seen = 0; mism = 0;
    width_err = 0; gap_err = 0; oh_err = 0; busy_err = 0;
    build_model(a);
    obs_q.delete();
    @(negedge clk);
    amount = AMT_W'(a);
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    amount = AMT_W'($urandom);
    while (c < 300) begin
      @(negedge clk);
      cur = q_out ? 3 : di_out ? 2 : n_out ? 1 : 0;
      if ($countones({q_out, di_out, n_out}) > 1 || (cur != 0 && !busy)) oh_err++;
      if (cur != 0) begin
        if (width == 0) begin
          obs_q.push_back(cur);
          if (seen != 0 && low != G + 1) gap_err++;
        end else if (cur != obs_q[$]) begin
          gap_err++;
        end
        width++;
        low = 0;
      end else begin
        if (width > 0) begin
          if (width != P) width_err++;
          width = 0;
          seen  = 1;
        end
        low++;
      end
      if (done) begin
        done_cnt++;
        if (done_c < 0) done_c = c;
      end
      if (!busy && done_c >= 0) begin
        fall_c = c;
        break;
      end
      if (!busy) busy_err++;
      if (c == inject_c) begin
        start  = 1'b1;
        amount = AMT_W'(25);
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      c++;
    end
    start = 1'b0;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      if (exp_q[i] != obs_q[i]) mism++;
    chk({tag, " coin_count"}, obs_q.size(), exp_q.size());
    chk({tag, " coin_order"}, mism, 0);
    chk({tag, " pulse_width_errs"}, width_err, 0);
    chk({tag, " gap_errs"}, gap_err, 0);
    chk({tag, " onehot_errs"}, oh_err, 0);
    chk({tag, " busy_drop_errs"}, busy_err, 0);
    chk({tag, " done_edge"}, done_c, 2 + exp_q.size() * (1 + P + G));
    chk({tag, " busy_fall_edge"}, fall_c, done_c + 1);
    chk({tag, " done_pulses"}, done_cnt, 1);
  endtask

  task automatic reject(input int a, input string tag);
    int act;
    act = 0;
    @(negedge clk);
    amount = AMT_W'(a);
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk({tag, " err"}, int'(err), 1);
    chk({tag, " busy"}, int'(busy), 0);
    repeat (6) begin
      @(negedge clk);
      if (outs() != 0) act++;
    end
    chk({tag, " idle_after"}, act, 0);
  endtask

  initial begin
    int k;
    rst = 1'b1; start = 1'b0; amount = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", outs(), 0);
    rst = 1'b0;

    payout(40, -1, "a40");
    payout(0, -1, "a0");
    reject(7, "a7");
    payout(255, -1, "a255");
    payout(65, 10, "a65_restart");
    repeat (8) payout(int'($urandom_range(0, 51)) * 5, -1, "rand");
    repeat (3) reject(int'($urandom_range(0, 50)) * 5 + int'($urandom_range(1, 4)), "rand_rej");

    @(negedge clk);
    amount = AMT_W'(50);
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    k = 0;
    while (!q_out && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("rst_mid q_seen", int'(q_out), 1);
    #2 rst = 1'b1;
    #1 chk("rst_mid async_clear", outs(), 0);
    @(posedge clk);
    #1 chk("rst_mid held", outs(), 0);
    @(negedge clk);
    rst = 1'b0;
    payout(5, -1, "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule
